// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive register family:
// FSM state encoding, default word width and the even-parity helper.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam int SERIAL_WIDTH_DEF = 8;

  // Words narrower than 32 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_tx_shifter.sv
// Parallel-in, serial-out shifter with valid/ready load and back-to-back words.
// Optional trailing even-parity bit when SERIAL_TX_PARITY_EN is defined.
module serial_tx_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH     = SERIAL_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
  localparam logic [1:0]     S_IDLE   = ST_IDLE;
  localparam logic [1:0]     S_SHIFT  = ST_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [1:0]     S_PARITY = ST_PARITY;
`endif

  // Load handshake: a word moves from producer to shifter on the clk edge
  // where load_valid && load_ready; load_ready depends only on state/counter.
  logic [1:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             ser_out_n;
  logic             done_n;
  logic             fire;
`ifdef SERIAL_TX_PARITY_EN
  logic             par, par_n;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  always_comb begin
    load_ready = 1'b0;
    case (state)
      S_IDLE:   load_ready = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      S_SHIFT:  load_ready = 1'b0;
      S_PARITY: load_ready = 1'b1;
`else
      S_SHIFT:  load_ready = (cnt == LAST);
`endif
      default:  load_ready = 1'b0;
    endcase
  end

  assign fire      = load_valid && load_ready;
  assign state_dbg = state;

  // Non-load transitions first; an accepted load then overrides them, since
  // every state that raises load_ready reloads straight into SHIFT.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      S_IDLE: state_n = S_IDLE;
      S_SHIFT: begin
        if (cnt == LAST) begin
`ifdef SERIAL_TX_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_IDLE;
`endif
        end else begin
          cnt_n   = cnt + 1'b1;
          shreg_n = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: state_n = S_IDLE;
`endif
      default: state_n = S_IDLE;
    endcase

    if (fire) begin
      state_n = S_SHIFT;
      cnt_n   = '0;
      shreg_n = data_in;
`ifdef SERIAL_TX_PARITY_EN
      par_n   = even_parity(32'(data_in));
`endif
    end
  end

  // Outputs are registered from next-state values so they line up with state.
  always_comb begin
    ser_out_n = 1'b0;
    done_n    = 1'b0;
    if (state_n == S_SHIFT) begin
      ser_out_n = head_bit(shreg_n);
`ifndef SERIAL_TX_PARITY_EN
      done_n    = (cnt_n == LAST);
`endif
    end
`ifdef SERIAL_TX_PARITY_EN
    if (state_n == S_PARITY) begin
      ser_out_n = par_n;
      done_n    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      ser_out   <= ser_out_n;
      ser_valid <= (state_n != S_IDLE);
      busy      <= (state_n != S_IDLE);
      done      <= done_n;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else        par <= par_n;
  end
`endif

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: LSB-first and MSB-first instances share stimulus
// and are checked against per-instance queues of expected {done, bit} cycles.
module tb_serial_tx_shifter;
  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] data_in = '0;

  logic       lr_a, so_a, sv_a, busy_a, dn_a;
  logic       lr_b, so_b, sv_b, busy_b, dn_b;
  logic [1:0] st_a, st_b;

  int total = 0;
  int bad   = 0;

  // Each entry is one expected serial cycle: {done, ser_out}.
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];

  serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr_a),
    .data_in(data_in), .ser_out(so_a), .ser_valid(sv_a), .busy(busy_a),
    .done(dn_a), .state_dbg(st_a)
  );

  serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr_b),
    .data_in(data_in), .ser_out(so_b), .ser_valid(sv_b), .busy(busy_b),
    .done(dn_b), .state_dbg(st_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    logic last;
    for (int i = 0; i < W; i++) begin
      last = (i == W - 1) && !PAR;
      exp_a.push_back({last, w[i]});
      exp_b.push_back({last, w[W-1-i]});
    end
    if (PAR) begin
      exp_a.push_back({1'b1, ^w});
      exp_b.push_back({1'b1, ^w});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ser_valid_a"}, sv_a, 0);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_ser_out_a"}, so_a, 0);
    check({tag, "_done_a"}, dn_a, 0);
    check({tag, "_load_ready_a"}, lr_a, 1);
    check({tag, "_ser_valid_b"}, sv_b, 0);
    check({tag, "_busy_b"}, busy_b, 0);
    check({tag, "_load_ready_b"}, lr_b, 1);
  endtask

  // One clock cycle: compare this cycle's outputs, offer a load, advance.
  task automatic step(input logic v, input logic [W-1:0] d, output bit acc);
    logic [1:0] ca, cb;
    bit va, vb;
    va = exp_a.size() > 0;
    ca = va ? exp_a.pop_front() : 2'b00;
    vb = exp_b.size() > 0;
    cb = vb ? exp_b.pop_front() : 2'b00;
    check("ser_valid_a", sv_a, va);
    check("ser_out_a", so_a, ca[0]);
    check("done_a", dn_a, ca[1]);
    check("busy_a", busy_a, va);
    check("ser_valid_b", sv_b, vb);
    check("ser_out_b", so_b, cb[0]);
    check("done_b", dn_b, cb[1]);
    check("busy_b", busy_b, vb);
    check("load_ready_a", lr_a, exp_a.size() == 0);
    check("load_ready_b", lr_b, exp_b.size() == 0);
    load_valid = v;
    data_in    = d;
    acc = v && (exp_a.size() == 0);
    if (acc) push_word(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), acc);
  endtask

  initial begin
    bit acc;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    idle(10);

    step(1'b1, 8'hA5, acc);
    idle(10);

    step(1'b1, 8'h0F, acc);
    n = 0;
    do begin
      step(1'b1, 8'hF0, acc);
      n++;
    end while (!acc && n < 20);
    check("b2b_second_accepted", acc, 1);
    idle(12);

    step(1'b1, 8'h80, acc);
    idle(12);

    step(1'b1, 8'h07, acc);
    idle(12);
    step(1'b1, 8'h03, acc);
    idle(12);

    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, W'($urandom), acc);
    idle(12);

    step(1'b1, 8'hFF, acc);
    idle(4);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    exp_a.delete();
    exp_b.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(12);
    step(1'b1, 8'h5A, acc);
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
